// File: rtl/ser_arb_ctrl_pkg.sv
// Shared types and default sizes for the serializer arbiter.
package ser_arb_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ser_arb_ctrl_if.sv
// Requester-side bus of the serializer arbiter: requests and words in,
// grant/ack/serial stream out.
interface ser_arb_ctrl_if import ser_arb_pkg::*; #(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] data;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic                   sout;
    logic                   sout_valid;
    logic                   busy;

    modport master (
        output req, data,
        input  gnt, ack, sout, sout_valid, busy
    );

    modport slave (
        input  req, data,
        output gnt, ack, sout, sout_valid, busy
    );
endinterface

// File: rtl/ser_arb_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first active request found when
// searching upward from the pointer, wrapping past N_REQ-1 to 0.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] pointer,
    output logic [N_REQ-1:0] winner
);

    int   idx;
    logic found;

    // Scan N_REQ positions starting at the pointer; the first hit wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(pointer) + k) % N_REQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ser_arb_ctrl.sv
// Shares one MSB-first serializer among N_REQ requesters with round-robin
// arbitration. Define SER_ARB_PARITY_EN to append an even-parity bit to
// every frame (frames become WIDTH+1 bits).
module ser_arb_ctrl import ser_arb_pkg::*; #(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    ser_arb_ctrl_if.slave bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
`ifdef SER_ARB_PARITY_EN
    localparam int SR_W = WIDTH + 1;
`else
    localparam int SR_W = WIDTH;
`endif
    localparam int CNT_W = $clog2(SR_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SR_W - 1);

    state_t            state, state_next;
    logic [N_REQ-1:0]  gnt_q, gnt_next, winner;
    logic [SR_W-1:0]   sreg, sreg_next, load_word;
    logic [WIDTH-1:0]  word;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [PTR_W-1:0]  ptr, ptr_next, gnt_idx, ptr_after;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req     (bus.req),
        .pointer (ptr),
        .winner  (winner)
    );

    // Pick the candidate winner's word out of the packed data bus.
    always_comb begin
        word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner[i]) begin
                word = word | bus.data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef SER_ARB_PARITY_EN
    assign load_word = {word, ^word};
`else
    assign load_word = word;
`endif

    // Encode the held grant and compute the pointer slot just after it.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
        ptr_after = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    // Next-state, datapath updates and output decode.
    always_comb begin
        state_next     = state;
        gnt_next       = gnt_q;
        sreg_next      = sreg;
        cnt_next       = cnt;
        ptr_next       = ptr;
        bus.gnt        = gnt_q;
        bus.ack        = '0;
        bus.sout_valid = 1'b0;
        bus.sout       = 1'b0;
        bus.busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    gnt_next   = winner;
                    sreg_next  = load_word;
                    cnt_next   = LAST_CNT;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                bus.sout_valid = 1'b1;
                bus.sout       = sreg[SR_W-1];
                sreg_next      = {sreg[SR_W-2:0], 1'b0};
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                bus.ack    = gnt_q;
                gnt_next   = '0;
                ptr_next   = ptr_after;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, shift register, bit counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q <= '0;
            sreg  <= '0;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            gnt_q <= gnt_next;
            sreg  <= sreg_next;
            cnt   <= cnt_next;
            ptr   <= ptr_next;
        end
    end

endmodule

// File: doc/ser_arb_ctrl.md
SER_ARB_CTRL -- requirements
Module: ser_arb_ctrl

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing the serializer.
REQ-002 Parameter WIDTH, default 8, SHALL set the bits per frame.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 req  input  N_REQ  SHALL carry per-requester transmit requests, held high until the matching ack.
REQ-006 data  input  N_REQ*WIDTH  SHALL carry packed parallel words, requester i at bits [i*WIDTH +: WIDTH], stable while req[i] is high.
REQ-007 gnt  output  N_REQ  SHALL be the one-hot grant, high for the whole frame of the granted requester.
REQ-008 ack  output  N_REQ  SHALL pulse one cycle for the granted requester when its frame completes.
REQ-009 sout  output  1  SHALL be the serial data, MSB first.
REQ-010 sout_valid  output  1  SHALL be high exactly on cycles where sout carries a frame bit.
REQ-011 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 IDLE: if req is nonzero at a clock edge, the block SHALL, on that edge, select a winner by round-robin, assert gnt, load the shift register with the winner's word, load bit counter with WIDTH-1, and enter SHIFT.
REQ-014 SHIFT: sout SHALL equal shift-register MSB with sout_valid=1; each edge SHALL shift left (zero fill) and decrement the counter; at counter 0 the FSM SHALL enter DONE.
REQ-015 DONE: ack[winner] SHALL be 1 for one cycle, sout_valid=0; on exit gnt SHALL clear, the round-robin pointer SHALL become winner+1 (mod N_REQ), and the FSM SHALL return to IDLE.
REQ-016 Round-robin: search SHALL start at the pointer and wrap; pointer reset value 0; index N_REQ-1 SHALL wrap to 0.
REQ-017 Frame latency: first bit on the cycle after the grant edge; sout_valid high for exactly WIDTH consecutive cycles; ack on the cycle immediately after the last bit.
REQ-018 A new grant SHALL occur no earlier than the IDLE cycle following DONE (one idle cycle between frames minimum).
REQ-019 Requests arriving or dropping during SHIFT/DONE SHALL not alter the current frame; a req deasserted mid-frame still receives its ack.
REQ-020 With req all-zero in IDLE, outputs SHALL hold reset values and the pointer SHALL not change.
REQ-021 When sout_valid=0, sout SHALL be 0.

Reset
REQ-022 Asserting rst in any state SHALL immediately force IDLE, gnt=0, ack=0, sout=0, sout_valid=0, busy=0, shift register=0, counter=0 and pointer=0; an interrupted frame SHALL be dropped with no ack.
REQ-023 After rst deasserts, the first grant SHALL occur at the first clock edge with req nonzero.

Configuration
REQ-024 Macro SER_ARB_PARITY_EN, when defined, SHALL append one even-parity bit (XOR of the WIDTH data bits) after the LSB, making frames WIDTH+1 bits with sout_valid high for WIDTH+1 cycles and ack delayed by one cycle.
REQ-025 Without SER_ARB_PARITY_EN, frames SHALL be exactly WIDTH bits and no parity logic SHALL exist.

Structure
REQ-026 Package ser_arb_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and default N_REQ/WIDTH constants.
REQ-027 Round-robin selection SHALL live in sub-module rr_arbiter (inputs req, pointer; output one-hot winner, combinational).

Verification
REQ-028 rst high mid-frame (cycle 3 of SHIFT) -> all outputs 0 next cycle, no ack, next req grants requester 0 first.
REQ-029 Only req[0], data word0=8'hA5 -> gnt=4'b0001, sout=1,0,1,0,0,1,0,1 over 8 valid cycles, ack=4'b0001 one cycle later.
REQ-030 req=4'b1111 held, words 8'h01/8'h02/8'h03/8'h04 -> grants in order 0,1,2,3,0, each frame 8 bits, one idle cycle between.
REQ-031 req[3] only, then req[0] during its frame -> requester 3 completes, pointer wraps, requester 0 granted next.
REQ-032 req[1] dropped on 2nd frame cycle -> frame completes all 8 bits, ack[1] still pulses.
REQ-033 SER_ARB_PARITY_EN defined, word 8'h07 -> 9 valid bits 0,0,0,0,0,1,1,1,1, ack one cycle after bit 9.
